// File: rtl/gf256_mult_seq.sv
// Sequential GF(2^8) multiplier, p = a*b mod x^8+x^4+x^3+x+1, one bit of b per cycle.
// Fixed latency; xfx_mult supplies the x-multiply-and-reduce step.

module xfx_mult (
   input  logic [7:0] f,
   output logic [7:0] v
);
   // xtime: shift left, fold x^8 back in as 0x1B
   assign v = {f[6:0], 1'b0} ^ (f[7] ? 8'h1B : 8'h00);
endmodule

module gf256_mult_seq (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] p,
   output logic [1:0] dbg_state
);
   // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
   // a/b are sampled only then, and p/out_valid hold until out_ready is seen.

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] sh_q, sh_d;
   logic [7:0] bb_q, bb_d;
   logic [7:0] acc_q, acc_d;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] sh_x;

   xfx_mult u_xfx (
      .f (sh_q),
      .v (sh_x)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sh_q    <= 8'h00;
         bb_q    <= 8'h00;
         acc_q   <= 8'h00;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         bb_q    <= bb_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      bb_d    = bb_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               sh_d    = a;
               bb_d    = b;
               acc_d   = 8'h00;
               cnt_d   = 3'd0;
               state_d = RUN;
            end
         end
         RUN: begin
            // Always eight iterations so timing never depends on operand values
            acc_d = acc_q ^ (bb_q[0] ? sh_q : 8'h00);
            sh_d  = sh_x;
            bb_d  = {1'b0, bb_q[7:1]};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign in_ready  = rst_n && (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign p         = acc_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_gf256_mult_seq.sv
// Directed bench for gf256_mult_seq: vector table plus back-pressure, reset-abort
// and back-to-back sequences.

module tb_gf256_mult_seq;
   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] p;
   logic [1:0] dbg_state;

   int n_checks;
   int n_errors;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] p;
   } vec_t;

   vec_t vecs[6];

   gf256_mult_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .p         (p),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Called just after a negedge with the DUT idle; returns after the out handshake.
   task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_op, input logic [7:0] exp_p,
                         input string name);
      int lat;
      bit ready_leak;
      check({name, " in_ready idle"}, in_ready, 1'b1);
      a = ta; b = tb_op; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      a = ~ta; b = ~tb_op;
      lat = 1;
      ready_leak = 1'b0;
      while (!out_valid && lat < 20) begin
         if (in_ready) ready_leak = 1'b1;
         @(negedge clk);
         lat++;
      end
      check({name, " latency"}, lat, 9);
      check({name, " p"}, p, exp_p);
      check({name, " in_ready low busy"}, ready_leak, 1'b0);
      @(negedge clk);
      check({name, " out_valid drop"}, out_valid, 1'b0);
      check({name, " in_ready back"}, in_ready, 1'b1);
   endtask

   initial begin
      logic [7:0] got_p[$];
      int         acc_t[$];
      bit         seen_out;

      n_checks = 0; n_errors = 0; cyc = 0;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = 8'h00; b = 8'h00;

      vecs[0] = '{a: 8'h57, b: 8'h83, p: 8'hC1};
      vecs[1] = '{a: 8'h53, b: 8'hCA, p: 8'h01};
      vecs[2] = '{a: 8'hFF, b: 8'h00, p: 8'h00};
      vecs[3] = '{a: 8'h57, b: 8'h13, p: 8'hFE};
      vecs[4] = '{a: 8'h80, b: 8'h02, p: 8'h1B};
      vecs[5] = '{a: 8'h00, b: 8'h01, p: 8'h00};

      // reset: 3 cycles
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset in_ready", in_ready, 1'b0);
      check("reset out_valid", out_valid, 1'b0);
      check("reset p", p, 8'h00);
      check("reset state", dbg_state, 2'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post-reset in_ready", in_ready, 1'b1);

      for (int i = 0; i < 6; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));
      end

      // back-pressure: product held while out_ready low, new operands ignored
      out_ready = 1'b0;
      a = 8'h01; b = 8'hA5; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (8) @(negedge clk);
      check("bp out_valid", out_valid, 1'b1);
      check("bp p", p, 8'hA5);
      a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("bp hold valid %0d", k), out_valid, 1'b1);
         check($sformatf("bp hold p %0d", k), p, 8'hA5);
         check($sformatf("bp in_ready %0d", k), in_ready, 1'b0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("bp release valid", out_valid, 1'b0);
      check("bp release in_ready", in_ready, 1'b1);

      // reset mid-RUN aborts the product
      a = 8'h57; b = 8'h83; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("abort out_valid", out_valid, 1'b0);
      check("abort p", p, 8'h00);
      check("abort in_ready", in_ready, 1'b0);
      rst_n = 1'b1;
      seen_out = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (out_valid) seen_out = 1'b1;
      end
      check("abort no output", seen_out, 1'b0);
      run_op(8'h57, 8'h13, 8'hFE, "after abort");

      // back-to-back with in_valid held high
      a = 8'h02; b = 8'h87; in_valid = 1'b1; out_ready = 1'b1;
      for (int k = 0; k < 30; k++) begin
         if (acc_t.size() == 1) begin a = 8'h03; b = 8'h03; end
         if (acc_t.size() == 2) in_valid = 1'b0;
         if (in_valid && in_ready) acc_t.push_back(cyc);
         if (out_valid && out_ready) got_p.push_back(p);
         @(negedge clk);
      end
      check("b2b accept count", acc_t.size(), 2);
      check("b2b product count", got_p.size(), 2);
      if (acc_t.size() == 2) check("b2b accept spacing", acc_t[1] - acc_t[0], 10);
      if (got_p.size() >= 1) check("b2b p0", got_p[0], 8'h15);
      if (got_p.size() >= 2) check("b2b p1", got_p[1], 8'h05);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
